// File: rtl/div_ctrl_if.sv
// Handshake and operand bundle between the execute stage and the RV32M divide sequencer.
interface div_ctrl_if #(
   parameter int XLEN = 32
);
   logic            div_start;
   logic [2:0]      div_op;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            div_reg_write;

   modport master (
      output div_start, div_op, rs1_val, rs2_val, rd_in, flush,
      input  busy, stall, done, result, rd_out, div_reg_write
   );

   modport slave (
      input  div_start, div_op, rs1_val, rs2_val, rd_in, flush,
      output busy, stall, done, result, rd_out, div_reg_write
   );
endinterface

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring divide with sign/special-case fixup.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow skip the RUN phase.
module div_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input logic       clk,
   input logic       rst_n,
   div_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   state_t          state_next;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] dvd;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dividend_raw;
   logic [XLEN-1:0] result_q;
   logic [4:0]      rd_q;
   logic            is_rem_q;
   logic            q_neg_q;
   logic            r_neg_q;
   logic            dvs_zero_q;
   logic            ovf_q;

   logic            op_signed;
   logic            op_rem;
   logic            start_zero;
   logic            start_ovf;
   logic            start_accept;
   logic [XLEN-1:0] rs1_abs;
   logic [XLEN-1:0] rs2_abs;
   logic [XLEN-1:0] rem_shift;
   logic [XLEN:0]   diff;
   logic            step_ge;
   logic [XLEN-1:0] fix_result;

   // Unlisted funct3 codes fall through to DIVU because neither flag is set.
   assign op_signed    = (bus.div_op == 3'b100) || (bus.div_op == 3'b110);
   assign op_rem       = (bus.div_op == 3'b110) || (bus.div_op == 3'b111);
   assign start_zero   = (bus.rs2_val == '0);
   assign start_ovf    = op_signed && (bus.rs1_val == INT_MIN) && (bus.rs2_val == '1);
   assign start_accept = (state == IDLE) && bus.div_start && !bus.flush;
   assign rs1_abs      = (op_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
   assign rs2_abs      = (op_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;

   // The extra top bit of the subtraction is the borrow: clear means rem_shift >= dvs.
   assign rem_shift = {rem[XLEN-2:0], dvd[XLEN-1]};
   assign diff      = {1'b0, rem_shift} - {1'b0, dvs};
   assign step_ge   = ~diff[XLEN];

   always_comb begin
      fix_result = '0;
      if (dvs_zero_q) begin
         fix_result = is_rem_q ? dividend_raw : '1;
      end else if (ovf_q) begin
         fix_result = is_rem_q ? '0 : INT_MIN;
      end else if (is_rem_q) begin
         fix_result = r_neg_q ? -rem : rem;
      end else begin
         fix_result = q_neg_q ? -dvd : dvd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_accept) begin
`ifdef DIV_FAST_PATH_EN
               state_next = (start_zero || start_ovf) ? FIX : RUN;
`else
               state_next = RUN;
`endif
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_next = FIX;
            end
         end
         FIX: begin
            state_next = bus.flush ? IDLE : DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Quotient bits are shifted into the low end of dvd as the dividend bits leave the top.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt          <= '0;
         dvd          <= '0;
         dvs          <= '0;
         rem          <= '0;
         dividend_raw <= '0;
         result_q     <= '0;
         rd_q         <= '0;
         is_rem_q     <= 1'b0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
         dvs_zero_q   <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_accept) begin
                  is_rem_q     <= op_rem;
                  q_neg_q      <= op_signed && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
                  r_neg_q      <= op_signed && bus.rs1_val[XLEN-1];
                  dvs_zero_q   <= start_zero;
                  ovf_q        <= start_ovf;
                  dividend_raw <= bus.rs1_val;
                  dvd          <= rs1_abs;
                  dvs          <= rs2_abs;
                  rem          <= '0;
                  cnt          <= '0;
                  rd_q         <= bus.rd_in;
               end
            end
            RUN: begin
               if (!bus.flush) begin
                  rem <= step_ge ? diff[XLEN-1:0] : rem_shift;
                  dvd <= {dvd[XLEN-2:0], step_ge};
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FIX: begin
               if (!bus.flush) begin
                  result_q <= fix_result;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy          = (state != IDLE);
   assign bus.stall         = (bus.div_start && (state == IDLE)) || (state == RUN) || (state == FIX);
   assign bus.done          = (state == DONE);
   assign bus.result        = result_q;
   assign bus.rd_out        = rd_q;
   assign bus.div_reg_write = (state == DONE) && (rd_q != 5'd0);

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table through a scoreboard plus flush/reset/back-to-back sequences.
module tb_div_ctrl;

   localparam int XLEN = 32;
`ifdef DIV_FAST_PATH_EN
   localparam int FAST_LAT = 2;
`else
   localparam int FAST_LAT = 34;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
      bit          special;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        wr;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_ctrl_if #(.XLEN(XLEN)) bus ();

   div_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   exp_t sb[$];
   vec_t vecs[19];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   task automatic driveStart(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
      @(negedge clk);
      bus.div_op    = op;
      bus.rs1_val   = a;
      bus.rs2_val   = b;
      bus.rd_in     = rd;
      bus.div_start = 1'b1;
      #1;
      checkOutput("stall_on_start", {31'b0, bus.stall}, 32'd1);
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] res, input bit special);
      exp_t e;
      driveStart(op, a, b, rd);
      e.res = res;
      e.rd  = rd;
      e.wr  = (rd != 5'd0);
      e.lat = special ? FAST_LAT : 34;
      sb.push_back(e);
   endtask

   task automatic waitDone(input string tag);
      int   lat;
      int   gaps;
      bit   seen;
      exp_t e;
      lat  = 0;
      gaps = 0;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.div_start = 1'b0;
         if (bus.done) seen = 1'b1;
         else if (!bus.stall) gaps++;
      end
      if (!seen) begin
         checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
         sb.delete();
      end else if (sb.size() == 0) begin
         checkOutput({tag, "_unexpected_done"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, "_result"}, bus.result, e.res);
         checkOutput({tag, "_rd_out"}, {27'b0, bus.rd_out}, {27'b0, e.rd});
         checkOutput({tag, "_reg_write"}, {31'b0, bus.div_reg_write}, {31'b0, e.wr});
         checkOutput({tag, "_latency"}, lat, e.lat);
         checkOutput({tag, "_stall_held"}, gaps, 32'd0);
         @(negedge clk);
         checkOutput({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
         checkOutput({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
      end
   endtask

   task automatic countDones(input int cycles, output int dones);
      dones = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
   endtask

   task automatic backToBack;
      int   t;
      int   first_t;
      int   second_t;
      int   dones;
      exp_t e;
      @(negedge clk);
      bus.div_op    = 3'b101;
      bus.rs1_val   = 32'd50;
      bus.rs2_val   = 32'd5;
      bus.rd_in     = 5'd4;
      bus.div_start = 1'b1;
      sb.push_back('{res: 32'd10, rd: 5'd4, wr: 1'b1, lat: 34});
      @(negedge clk);
      bus.rs1_val = 32'd1000;
      bus.rs2_val = 32'd10;
      bus.rd_in   = 5'd8;
      sb.push_back('{res: 32'd100, rd: 5'd8, wr: 1'b1, lat: 0});
      t        = 1;
      first_t  = -1;
      second_t = -1;
      dones    = 0;
      while (t < 120 && dones < 2) begin
         @(negedge clk);
         t++;
         if (first_t >= 0 && t == first_t + 2) bus.div_start = 1'b0;
         if (bus.done && sb.size() != 0) begin
            dones++;
            e = sb.pop_front();
            checkOutput("b2b_result", bus.result, e.res);
            checkOutput("b2b_rd_out", {27'b0, bus.rd_out}, {27'b0, e.rd});
            if (dones == 1) first_t = t;
            else second_t = t;
         end
      end
      bus.div_start = 1'b0;
      checkOutput("b2b_done_count", dones, 32'd2);
      checkOutput("b2b_first_latency", first_t, 32'd34);
      checkOutput("b2b_spacing", second_t - first_t, 32'd35);
      sb.delete();
      @(negedge clk);
   endtask

   initial begin
      int dones;

      vecs[0]  = '{3'b100, 32'd100,      32'hFFFFFFF9, 5'd5,  32'hFFFFFFF2, 1'b0};
      vecs[1]  = '{3'b110, 32'hFFFFFF9C, 32'd7,        5'd6,  32'hFFFFFFFE, 1'b0};
      vecs[2]  = '{3'b111, 32'hFFFFFFFF, 32'd16,       5'd7,  32'h0000000F, 1'b0};
      vecs[3]  = '{3'b101, 32'hFFFFFFFF, 32'd2,        5'd8,  32'h7FFFFFFF, 1'b0};
      vecs[4]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 1'b1};
      vecs[5]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, 1'b1};
      vecs[6]  = '{3'b101, 32'd42,       32'd0,        5'd11, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{3'b110, 32'hFFFFFFF7, 32'd0,        5'd12, 32'hFFFFFFF7, 1'b1};
      vecs[8]  = '{3'b100, 32'd9,        32'd3,        5'd0,  32'h00000003, 1'b0};
      vecs[9]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 1'b0};
      vecs[11] = '{3'b000, 32'hFFFFFFF0, 32'd16,       5'd15, 32'h0FFFFFFF, 1'b0};
      vecs[12] = '{3'b110, 32'd7,        32'hFFFFFFFD, 5'd16, 32'h00000001, 1'b0};
      vecs[13] = '{3'b100, 32'hFFFFFF9C, 32'hFFFFFFF9, 5'd31, 32'h0000000E, 1'b0};
      vecs[14] = '{3'b100, 32'hFFFFFFF7, 32'd0,        5'd17, 32'hFFFFFFFF, 1'b1};
      vecs[15] = '{3'b111, 32'h12345678, 32'd0,        5'd18, 32'h12345678, 1'b1};
      vecs[16] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 1'b0};
      vecs[17] = '{3'b111, 32'hDEADBEEF, 32'h00010000, 5'd20, 32'h0000BEEF, 1'b0};
      vecs[18] = '{3'b101, 32'hDEADBEEF, 32'h00010000, 5'd21, 32'h0000DEAD, 1'b0};

      bus.div_start = 1'b0;
      bus.div_op    = 3'b000;
      bus.rs1_val   = '0;
      bus.rs2_val   = '0;
      bus.rd_in     = '0;
      bus.flush     = 1'b0;

      $display("[TB] reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
      checkOutput("reset_result", bus.result, 32'd0);
      checkOutput("reset_rd_out", {27'b0, bus.rd_out}, 32'd0);
      checkOutput("reset_reg_write", {31'b0, bus.div_reg_write}, 32'd0);
      checkOutput("reset_stall", {31'b0, bus.stall}, 32'd0);

      $display("[TB] vector table");
      for (int i = 0; i < 19; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].special);
         waitDone($sformatf("vec%0d", i));
      end

      // Flush partway through RUN must drop the operation without a done pulse.
      $display("[TB] flush in RUN");
      driveStart(3'b100, 32'd100, 32'd7, 5'd3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.div_start = 1'b0;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("flush_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("flush_done", {31'b0, bus.done}, 32'd0);
      countDones(40, dones);
      checkOutput("flush_no_done", dones, 32'd0);
      applyStimulus(3'b100, 32'd9, 32'd3, 5'd7, 32'd3, 1'b0);
      waitDone("after_flush");

      $display("[TB] flush with start in IDLE");
      @(negedge clk);
      bus.div_op    = 3'b101;
      bus.rs1_val   = 32'd8;
      bus.rs2_val   = 32'd2;
      bus.rd_in     = 5'd9;
      bus.div_start = 1'b1;
      bus.flush     = 1'b1;
      @(negedge clk);
      bus.div_start = 1'b0;
      bus.flush     = 1'b0;
      checkOutput("idle_flush_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("idle_flush_rd_out", {27'b0, bus.rd_out}, 32'd7);

      $display("[TB] reset in RUN");
      driveStart(3'b101, 32'd1000, 32'd10, 5'd9);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.div_start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("midrst_done", {31'b0, bus.done}, 32'd0);
      checkOutput("midrst_result", bus.result, 32'd0);
      checkOutput("midrst_rd_out", {27'b0, bus.rd_out}, 32'd0);
      checkOutput("midrst_reg_write", {31'b0, bus.div_reg_write}, 32'd0);
      rst_n = 1'b1;
      countDones(40, dones);
      checkOutput("midrst_no_done", dones, 32'd0);

      $display("[TB] held start and back-to-back");
      backToBack();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
